// File: rtl/rv32i_types.sv
// Shared types for the data-memory responder.
//   dmem_resp_state_t : controller state (IDLE / WAIT / RESP)
//   dmem_req_t        : request fields latched on acceptance
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_resp_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_sram_array.sv
// Synchronous 1R/1W word array with per-byte write enables.
//   clk     : clock
//   rd_en   : read strobe; rd_data updates on the next edge
//   rd_idx  : word index to read
//   rd_data : registered read word (holds until the next read)
//   wr_en   : write strobe
//   wr_idx  : word index to write
//   wr_be   : byte-lane write enables
//   wr_data : lane-aligned write data
// Contents are not reset.
module dmem_sram_array #(
  parameter int unsigned DEPTH_BITS = 10
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [DEPTH_BITS-1:0] rd_idx,
  output logic [31:0]           rd_data,
  input  logic                  wr_en,
  input  logic [DEPTH_BITS-1:0] wr_idx,
  input  logic [3:0]            wr_be,
  input  logic [31:0]           wr_data
);

  logic [31:0] mem [2**DEPTH_BITS];
  logic [31:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
    if (rd_en) rd_data_q <= mem[rd_idx];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: target side of the core's dmem request/response
// interface, backed by an on-chip word array.
//   clk, rst    : clock, synchronous active-high reset
//   dmem_addr   : byte address (bits [1:0] ignored)
//   dmem_rmask  : read byte enables
//   dmem_wmask  : write byte enables
//   dmem_wdata  : lane-aligned write data
//   dmem_rdata  : full read word, valid while dmem_resp=1
//   dmem_resp   : one-cycle response strobe
//   dmem_err    : error flag, qualified by dmem_resp
//   resp_stall  : latency injection while waiting (tie 0 in synthesis)
//   busy        : high from acceptance through the response cycle
module dmem_responder
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH_BITS = 10,
  parameter int unsigned LATENCY    = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h1ECE_B000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic        dmem_err,
  input  logic        resp_stall,
  output logic        busy
);

  if (LATENCY == 0 || LATENCY > 15) begin : g_latency_range
    $error("dmem_responder: LATENCY must be within 1..15");
  end

  localparam logic [3:0]  LAT_M1    = 4'(LATENCY - 1);
  localparam logic [31:0] ADDR_MASK = ~((32'd4 << DEPTH_BITS) - 32'd1);

  function automatic logic req_is_err(input dmem_req_t r);
    return ((r.addr & ADDR_MASK) != BASE_ADDR) || ((|r.rmask) && (|r.wmask));
  endfunction

  dmem_resp_state_t state_q, state_d;
  dmem_req_t        req_q, req_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             resp_q, resp_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  logic                  req_valid;
  logic                  rd_en;
  logic [DEPTH_BITS-1:0] rd_idx;
  logic                  wr_en;
  logic [31:0]           arr_rdata;

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    cnt_d     = cnt_q;
    rd_en     = 1'b0;
    rd_idx    = req_q.addr[DEPTH_BITS+1:2];
    req_valid = (|dmem_rmask) | (|dmem_wmask);

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d = '{addr: dmem_addr, rmask: dmem_rmask,
                    wmask: dmem_wmask, wdata: dmem_wdata};
          cnt_d = LAT_M1;
          if (LATENCY == 1) begin
            // No WAIT cycle: read straight from the live address so the
            // registered array output is ready in RESP.
            state_d = RESP;
            rd_en   = 1'b1;
            rd_idx  = dmem_addr[DEPTH_BITS+1:2];
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!resp_stall) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            // Read is issued on the edge entering RESP.
            state_d = RESP;
            rd_en   = 1'b1;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    resp_d = (state_d == RESP);
    err_d  = (state_d == RESP) ? req_is_err(req_d) : 1'b0;
    busy_d = (state_d != IDLE);
  end

  // Write commits on the RESP edge unless reset lands on that same edge.
  assign wr_en = (state_q == RESP) && !err_q && (|req_q.wmask) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    req_q <= req_d;
  end

  dmem_sram_array #(
    .DEPTH_BITS(DEPTH_BITS)
  ) u_array (
    .clk    (clk),
    .rd_en  (rd_en),
    .rd_idx (rd_idx),
    .rd_data(arr_rdata),
    .wr_en  (wr_en),
    .wr_idx (req_q.addr[DEPTH_BITS+1:2]),
    .wr_be  (req_q.wmask),
    .wr_data(req_q.wdata)
  );

  // Reset in the RESP cycle kills the strobe in that same cycle.
  assign dmem_resp  = resp_q & ~rst;
  assign dmem_err   = err_q & resp_q & ~rst;
  assign dmem_rdata = (resp_q && !err_q && !rst) ? arr_rdata : 'x;
  assign busy       = busy_q;

endmodule
